// File: rtl/quadrilatero_sa_scheduler.sv
// Systolic-array instruction scheduler with a small in-order queue and an in-flight scoreboard.
// Latency: accepted instruction to start_o is at least 1 cycle; finished_i to retire/ack is combinational.
// Backpressure: instr_ready_o drops on full queue or outside RUN; issue stalls on sa_ready_i, full scoreboard, or RAW/WAW hazard when QUADRILATERO_SCHED_HAZARD_EN is defined.

// Generic synchronous FIFO, head shown continuously, no write-to-read bypass.
// Latency: pushed word visible at dat_o the cycle after the push.
// Backpressure: full_o/empty_o come from registered pointers; push when full and pop when empty are dropped.
module quadrilatero_sa_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dat_o   = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the head reads zero before the first push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_i && !full_o) begin
                mem[wr_ptr[AW-1:0]] <= dat_i;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop_i && !empty_o) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

module quadrilatero_sa_scheduler #(
    parameter int N_REGS       = 8,
    parameter int ID_WIDTH     = 4,
    parameter int QUEUE_DEPTH  = 4,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      instr_valid_i,
    output logic                      instr_ready_o,
    input  logic [$clog2(N_REGS)-1:0] instr_data_reg_i,
    input  logic [$clog2(N_REGS)-1:0] instr_acc_reg_i,
    input  logic [$clog2(N_REGS)-1:0] instr_weight_reg_i,
    input  logic [3:0]                instr_sa_ctrl_i,
    input  logic [ID_WIDTH-1:0]       instr_id_i,
    input  logic                      sa_ready_i,
    output logic                      start_o,
    output logic [$clog2(N_REGS)-1:0] data_reg_o,
    output logic [$clog2(N_REGS)-1:0] acc_reg_o,
    output logic [$clog2(N_REGS)-1:0] weight_reg_o,
    output logic [3:0]                sa_ctrl_o,
    output logic [ID_WIDTH-1:0]       id_o,
    input  logic                      finished_i,
    input  logic [ID_WIDTH-1:0]       finished_instr_id_i,
    output logic                      finished_ack_o,
    output logic                      retire_valid_o,
    input  logic                      retire_ready_i,
    output logic [ID_WIDTH-1:0]       retire_id_o,
    input  logic                      flush_i,
    output logic                      flush_done_o,
    output logic                      busy_o,
    output logic                      unknown_id_o
);
    localparam int RW  = $clog2(N_REGS);
    localparam int SBW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    typedef struct packed {
        logic [RW-1:0]       data_reg;
        logic [RW-1:0]       acc_reg;
        logic [RW-1:0]       weight_reg;
        logic [3:0]          sa_ctrl;
        logic [ID_WIDTH-1:0] id;
    } instr_t;

    typedef struct packed {
        logic                vld;
        logic [ID_WIDTH-1:0] id;
        logic [RW-1:0]       acc_reg;
    } sb_entry_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t    state;
    instr_t    push_dat;
    instr_t    head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      issue;
    sb_entry_t sb [MAX_INFLIGHT];
    logic      free_found;
    logic      hit_found;
    logic      sb_empty;
    logic      hazard;
    logic [SBW-1:0] free_idx;
    logic [SBW-1:0] hit_idx;

    assign push_dat = '{data_reg: instr_data_reg_i, acc_reg: instr_acc_reg_i,
                        weight_reg: instr_weight_reg_i, sa_ctrl: instr_sa_ctrl_i, id: instr_id_i};

    quadrilatero_sa_fifo #(.WIDTH($bits(instr_t)), .DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (instr_valid_i && instr_ready_o),
        .dat_i   (push_dat),
        .pop_i   (issue),
        .dat_o   (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // All scoreboard lookups see registered state, so a same-cycle retire cannot unblock issue.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        hit_found  = 1'b0;
        hit_idx    = '0;
        sb_empty   = 1'b1;
        hazard     = 1'b0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            if (!sb[i].vld && !free_found) begin
                free_found = 1'b1;
                free_idx   = SBW'(i);
            end
            if (sb[i].vld && (sb[i].id == finished_instr_id_i) && !hit_found) begin
                hit_found = 1'b1;
                hit_idx   = SBW'(i);
            end
            if (sb[i].vld) sb_empty = 1'b0;
`ifdef QUADRILATERO_SCHED_HAZARD_EN
            if (sb[i].vld && ((sb[i].acc_reg == head.data_reg) ||
                              (sb[i].acc_reg == head.weight_reg) ||
                              (sb[i].acc_reg == head.acc_reg))) hazard = 1'b1;
`endif
        end
    end

    assign issue          = !fifo_empty && sa_ready_i && free_found && !hazard && (state != IDLE);
    assign instr_ready_o  = !fifo_full && (state == RUN);
    assign start_o        = issue;
    assign data_reg_o     = head.data_reg;
    assign acc_reg_o      = head.acc_reg;
    assign weight_reg_o   = head.weight_reg;
    assign sa_ctrl_o      = head.sa_ctrl;
    assign id_o           = head.id;
    assign retire_valid_o = finished_i;
    assign retire_id_o    = finished_instr_id_i;
    assign finished_ack_o = finished_i && retire_ready_i;
    assign flush_done_o   = (state == DRAIN) && fifo_empty && sb_empty;
    assign busy_o         = !fifo_empty || !sb_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            unknown_id_o <= 1'b0;
            for (int i = 0; i < MAX_INFLIGHT; i++) sb[i] <= '0;
        end else begin
            if (finished_ack_o) begin
                if (hit_found) sb[hit_idx].vld <= 1'b0;
                else           unknown_id_o    <= 1'b1;
            end
            // A retiring entry is still valid here, so it never collides with the allocated slot.
            if (issue) begin
                sb[free_idx].vld     <= 1'b1;
                sb[free_idx].id      <= head.id;
                sb[free_idx].acc_reg <= head.acc_reg;
            end
            case (state)
                IDLE:    state <= RUN;
                RUN:     if (flush_i) state <= DRAIN;
                DRAIN:   if (flush_done_o) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quadrilatero_sa_scheduler.sv
// Directed bench for quadrilatero_sa_scheduler; expectations follow the hazard macro if it is defined.
module tb_quadrilatero_sa_scheduler;
    localparam int RW = 3;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [RW-1:0] instr_data;
    logic [RW-1:0] instr_acc;
    logic [RW-1:0] instr_weight;
    logic [3:0]    instr_ctrl;
    logic [IW-1:0] instr_id;
    logic          sa_ready;
    logic          start;
    logic [RW-1:0] data_reg;
    logic [RW-1:0] acc_reg;
    logic [RW-1:0] weight_reg;
    logic [3:0]    sa_ctrl;
    logic [IW-1:0] id_out;
    logic          finished;
    logic [IW-1:0] fin_id;
    logic          fin_ack;
    logic          retire_valid;
    logic          retire_ready;
    logic [IW-1:0] retire_id;
    logic          flush;
    logic          flush_done;
    logic          busy;
    logic          unknown_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    quadrilatero_sa_scheduler dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .instr_valid_i       (instr_valid),
        .instr_ready_o       (instr_ready),
        .instr_data_reg_i    (instr_data),
        .instr_acc_reg_i     (instr_acc),
        .instr_weight_reg_i  (instr_weight),
        .instr_sa_ctrl_i     (instr_ctrl),
        .instr_id_i          (instr_id),
        .sa_ready_i          (sa_ready),
        .start_o             (start),
        .data_reg_o          (data_reg),
        .acc_reg_o           (acc_reg),
        .weight_reg_o        (weight_reg),
        .sa_ctrl_o           (sa_ctrl),
        .id_o                (id_out),
        .finished_i          (finished),
        .finished_instr_id_i (fin_id),
        .finished_ack_o      (fin_ack),
        .retire_valid_o      (retire_valid),
        .retire_ready_i      (retire_ready),
        .retire_id_o         (retire_id),
        .flush_i             (flush),
        .flush_done_o        (flush_done),
        .busy_o              (busy),
        .unknown_id_o        (unknown_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input int d, input int w, input int a);
        instr_valid  = 1'b1;
        instr_id     = IW'(id);
        instr_data   = RW'(d);
        instr_weight = RW'(w);
        instr_acc    = RW'(a);
        instr_ctrl   = 4'(id) ^ 4'hA;
    endtask

    task automatic retire(input int id);
        finished = 1'b1;
        fin_id   = IW'(id);
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr_data = '0; instr_acc = '0; instr_weight = '0;
        instr_ctrl = '0; instr_id = '0; sa_ready = 1'b0; finished = 1'b0; fin_id = '0;
        retire_ready = 1'b0; flush = 1'b0;

        // reset values, ack follows finished_i combinationally
        repeat (2) @(negedge clk);
        finished = 1'b1; retire_ready = 1'b1; #1;
        chk("rst_ready", instr_ready, 0); chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);         chk("rst_flush_done", flush_done, 0);
        chk("rst_id", id_out, 0);         chk("rst_unknown", unknown_id, 0);
        chk("rst_ack", fin_ack, 1);       chk("rst_retire_valid", retire_valid, 1);
        finished = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        chk("idle_ready", instr_ready, 0);
        @(negedge clk); #1;
        chk("run_ready", instr_ready, 1);

        // single instruction issue and retire
        @(negedge clk); push(1, 0, 1, 2); sa_ready = 1'b1; #1;
        chk("s1_start_push_cycle", start, 0);
        @(negedge clk); instr_valid = 1'b0; #1;
        chk("s1_start", start, 1); chk("s1_id", id_out, 1); chk("s1_acc", acc_reg, 2);
        chk("s1_weight", weight_reg, 1); chk("s1_ctrl", sa_ctrl, 4'hB); chk("s1_busy", busy, 1);
        @(negedge clk); #1;
        chk("s1_start_once", start, 0); chk("s1_busy_inflight", busy, 1);
        @(negedge clk); retire(1); #1;
        chk("s1_ack", fin_ack, 1); chk("s1_retire_valid", retire_valid, 1); chk("s1_retire_id", retire_id, 1);
        @(negedge clk); finished = 1'b0; #1;
        chk("s1_idle_busy", busy, 0); chk("s1_unknown", unknown_id, 0);

        // dependent instruction behind an in-flight accumulator
        @(negedge clk); push(1, 0, 1, 2);
        @(negedge clk); push(2, 2, 3, 4); #1;
        chk("hz_start1", start, 1); chk("hz_id1", id_out, 1);
        @(negedge clk); instr_valid = 1'b0; #1;
`ifdef QUADRILATERO_SCHED_HAZARD_EN
        chk("hz_blocked", start, 0); chk("hz_head", id_out, 2);
        @(negedge clk); retire(1); #1;
        chk("hz_ack1", fin_ack, 1); chk("hz_still_blocked", start, 0);
        @(negedge clk); finished = 1'b0; #1;
        chk("hz_start2", start, 1); chk("hz_id2", id_out, 2);
        @(negedge clk); retire(2); #1;
        chk("hz_ack2", fin_ack, 1);
`else
        chk("hz_start2", start, 1); chk("hz_id2", id_out, 2);
        @(negedge clk); retire(1); #1;
        chk("hz_ack1", fin_ack, 1); chk("hz_no_start", start, 0);
        @(negedge clk); retire(2); #1;
        chk("hz_ack2", fin_ack, 1);
`endif
        @(negedge clk); finished = 1'b0; #1;
        chk("hz_busy", busy, 0); chk("hz_unknown", unknown_id, 0);

        // fill queue with array stalled, then drain with at most three outstanding
        @(negedge clk); sa_ready = 1'b0; push(1, 0, 1, 4); #1;
        chk("q_ready1", instr_ready, 1);
        @(negedge clk); push(2, 0, 1, 5); #1; chk("q_ready2", instr_ready, 1);
        @(negedge clk); push(3, 0, 1, 6); #1; chk("q_ready3", instr_ready, 1);
        @(negedge clk); push(4, 0, 1, 7); #1; chk("q_ready4", instr_ready, 1);
        @(negedge clk); push(5, 0, 1, 3); sa_ready = 1'b1; #1;
        chk("q_full_ready", instr_ready, 0); chk("q_start1", start, 1); chk("q_id1", id_out, 1);
        @(negedge clk); instr_valid = 1'b0; #1;
        chk("q_start2", start, 1); chk("q_id2", id_out, 2);
        @(negedge clk); #1;
        chk("q_start3", start, 1); chk("q_id3", id_out, 3);
        @(negedge clk); #1;
        chk("q_sb_full_stall", start, 0); chk("q_head4", id_out, 4); chk("q_ready_again", instr_ready, 1);
        @(negedge clk); retire(1); #1;
        chk("q_ack1", fin_ack, 1); chk("q_no_same_cycle_issue", start, 0);
        @(negedge clk); finished = 1'b0; #1;
        chk("q_start4", start, 1); chk("q_id4", id_out, 4);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk); retire(k); #1;
            chk("q_ack", fin_ack, 1);
        end
        @(negedge clk); finished = 1'b0; #1;
        chk("q_busy", busy, 0); chk("q_unknown", unknown_id, 0);

        // retire of an id that was never issued
        @(negedge clk); retire(7); retire_ready = 1'b0; #1;
        chk("u_ack_held", fin_ack, 0); chk("u_retire_valid", retire_valid, 1); chk("u_retire_id", retire_id, 7);
        @(negedge clk); retire_ready = 1'b1; #1;
        chk("u_ack", fin_ack, 1); chk("u_unknown_pre", unknown_id, 0);
        @(negedge clk); finished = 1'b0; #1;
        chk("u_unknown_set", unknown_id, 1);
        repeat (3) @(negedge clk); #1;
        chk("u_unknown_sticky", unknown_id, 1);

        // flush with nothing outstanding
        @(negedge clk); flush = 1'b1; #1;
        chk("fe_done_early", flush_done, 0);
        @(negedge clk); flush = 1'b0; #1;
        chk("fe_done", flush_done, 1); chk("fe_drain_ready", instr_ready, 0);
        @(negedge clk); #1;
        chk("fe_done_once", flush_done, 0); chk("fe_run_ready", instr_ready, 1);

        // flush with two queued instructions
        @(negedge clk); sa_ready = 1'b0; push(1, 0, 1, 2);
        @(negedge clk); push(2, 3, 4, 5);
        @(negedge clk); instr_valid = 1'b0; flush = 1'b1; #1;
        chk("f_ready_run", instr_ready, 1);
        @(negedge clk); flush = 1'b0; push(9, 0, 0, 0); sa_ready = 1'b1; #1;
        chk("f_ready_drain", instr_ready, 0); chk("f_start1", start, 1);
        chk("f_id1", id_out, 1); chk("f_done0", flush_done, 0);
        @(negedge clk); instr_valid = 1'b0; flush = 1'b1; #1;
        chk("f_start2", start, 1); chk("f_id2", id_out, 2); chk("f_done1", flush_done, 0);
        @(negedge clk); flush = 1'b0; retire(1); #1;
        chk("f_ack1", fin_ack, 1); chk("f_done2", flush_done, 0);
        @(negedge clk); retire(2); #1;
        chk("f_ack2", fin_ack, 1); chk("f_done3", flush_done, 0);
        @(negedge clk); finished = 1'b0; #1;
        chk("f_done", flush_done, 1); chk("f_busy", busy, 0);
        @(negedge clk); #1;
        chk("f_done_once", flush_done, 0); chk("f_run_ready", instr_ready, 1); chk("f_busy_after", busy, 0);

        // reset with two instructions in flight
        @(negedge clk); push(1, 0, 1, 2);
        @(negedge clk); push(2, 3, 4, 5); #1;
        chk("r_start1", start, 1);
        @(negedge clk); instr_valid = 1'b0; #1;
        chk("r_start2", start, 1);
        @(negedge clk); #1;
        chk("r_busy_pre", busy, 1);
        @(negedge clk); rst_n = 1'b0; retire(1); #1;
        chk("r_ready", instr_ready, 0); chk("r_start", start, 0); chk("r_busy", busy, 0);
        chk("r_flush_done", flush_done, 0); chk("r_id", id_out, 0); chk("r_data", data_reg, 0);
        chk("r_acc", acc_reg, 0); chk("r_weight", weight_reg, 0); chk("r_ctrl", sa_ctrl, 0);
        chk("r_unknown", unknown_id, 0); chk("r_ack", fin_ack, 1); chk("r_retire_valid", retire_valid, 1);
        @(negedge clk); finished = 1'b0; rst_n = 1'b1; #1;
        chk("r_idle_ready", instr_ready, 0); chk("r_idle_busy", busy, 0);
        @(negedge clk); #1;
        chk("r_run_ready", instr_ready, 1); chk("r_run_busy", busy, 0); chk("r_run_start", start, 0);
        @(negedge clk); retire(1); #1;
        chk("r_stale_ack", fin_ack, 1);
        @(negedge clk); finished = 1'b0; #1;
        chk("r_stale_unknown", unknown_id, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
